// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch (I) and load/store (D).
// D wins ties until it has taken MAX_D_STREAK grants in a row over a waiting fetch.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wmask,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata
);
    localparam int SW = (MAX_D_STREAK > 0) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    logic          owner_d;
    logic [SW-1:0] streak;
    logic          d_wins;

    // With MAX_D_STREAK=0 the streak is always saturated, so a waiting fetch wins every tie.
    assign d_wins = d_req && !(i_req && (streak >= STREAK_MAX));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner_d   <= 1'b0;
            streak    <= '0;
            i_gnt     <= 1'b0;
            i_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wmask <= '0;
        end else begin
            i_gnt    <= 1'b0;
            d_gnt    <= 1'b0;
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req || d_req) begin
                        mem_req <= 1'b1;
                        owner_d <= d_wins;
                        state   <= ISSUE;
                        if (d_wins) begin
                            d_gnt     <= 1'b1;
                            mem_we    <= d_we;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                            mem_wmask <= d_wmask;
                            if (!i_req)
                                streak <= '0;
                            else if (streak != STREAK_MAX)
                                streak <= streak + 1'b1;
                        end else begin
                            i_gnt     <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_addr  <= i_addr;
                            mem_wdata <= '0;
                            mem_wmask <= '0;
                            streak    <= '0;
                        end
                    end
                end
                ISSUE: begin
                    // Memory never answers in the accept cycle, so mem_rvalid is not looked at here.
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_rvalid) begin
                        if (owner_d) begin
                            d_rdata  <= mem_rdata;
                            d_rvalid <= 1'b1;
                        end else begin
                            i_rdata  <= mem_rdata;
                            i_rvalid <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: requester agents, a memory responder and a
// transaction-level reference model predicting grants, payloads and responses.
module tb_mem_port_arbiter;
    localparam int AW = 32, DW = 32, MW = 4, MAXS = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic          i_req = 0, d_req = 0, d_we = 0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;
    logic [MW-1:0] d_wmask = '0;
    logic          mem_ready = 0, mem_rvalid = 0;
    logic [DW-1:0] mem_rdata = '0;
    logic          i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_we;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_wmask;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // reference model: transaction phase 0 free, 1 offered to memory, 2 accepted
    int            phase = 0, streak = 0;
    bit            owner_d = 0;
    logic          e_mreq = 0, e_we = 0;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wdata = '0, e_ir = '0, e_dr = '0;
    logic [MW-1:0] e_wmask = '0;

    // memory responder and stimulus knobs
    logic [DW-1:0] mem [16];
    int  resp_cnt = -1, req_age = 0, rd_idx = 0;
    int  ready_hold = -1, rsp_fixed = -1;
    bit  spur_en = 0;
    int  i_mode = 0, d_mode = 0;
    bit  log_en = 0;
    byte glog[$];
    int  cnt_mreq = 0, cnt_irv = 0, cnt_drv = 0;

    task automatic cycle();
        logic p_rst, p_i_req, p_d_req, p_d_we, p_mrdy, p_mrv, p_mreq, p_mwe;
        logic [AW-1:0] p_i_addr, p_d_addr, p_maddr;
        logic [DW-1:0] p_d_wdata, p_mrdata, p_mwdata;
        logic [MW-1:0] p_d_wmask, p_mwmask;
        bit eig, edg, eir, edr, d_win, acc;
        p_rst = reset; p_i_req = i_req; p_i_addr = i_addr;
        p_d_req = d_req; p_d_we = d_we; p_d_addr = d_addr; p_d_wdata = d_wdata; p_d_wmask = d_wmask;
        p_mrdy = mem_ready; p_mrv = mem_rvalid; p_mrdata = mem_rdata;
        p_mreq = mem_req; p_mwe = mem_we; p_maddr = mem_addr; p_mwdata = mem_wdata; p_mwmask = mem_wmask;
        @(negedge clock);

        eig = 0; edg = 0; eir = 0; edr = 0;
        if (!p_rst) begin
            phase = 0; streak = 0; e_mreq = 0; e_we = 0; e_addr = '0;
            e_wdata = '0; e_wmask = '0; e_ir = '0; e_dr = '0;
        end else if (phase == 0) begin
            if (p_i_req || p_d_req) begin
                d_win = p_d_req && !(p_i_req && streak >= MAXS);
                if (d_win) begin
                    edg = 1; e_addr = p_d_addr; e_we = p_d_we; e_wdata = p_d_wdata; e_wmask = p_d_wmask;
                    streak = p_i_req ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
                end else begin
                    eig = 1; e_addr = p_i_addr; e_we = 0; e_wdata = '0; e_wmask = '0;
                    streak = 0;
                end
                owner_d = d_win; phase = 1; e_mreq = 1;
            end
        end else if (phase == 1) begin
            if (p_mrdy) begin phase = 2; e_mreq = 0; end
        end else if (p_mrv) begin
            if (owner_d) begin edr = 1; e_dr = p_mrdata; end
            else begin eir = 1; e_ir = p_mrdata; end
            phase = 0;
        end

        chk("pulses", {i_gnt, d_gnt, i_rvalid, d_rvalid}, {eig, edg, eir, edr});
        chk("mem_req", mem_req, e_mreq);
        chk("i_rdata", i_rdata, e_ir);
        chk("d_rdata", d_rdata, e_dr);
        if (e_mreq || !p_rst) begin
            chk("mem_addr", mem_addr, e_addr);
            chk("mem_we", mem_we, e_we);
            chk("mem_wdata", mem_wdata, e_wdata);
            chk("mem_wmask", mem_wmask, e_wmask);
        end
        cnt_mreq += int'(mem_req); cnt_irv += int'(i_rvalid); cnt_drv += int'(d_rvalid);
        if (log_en && d_gnt) glog.push_back("D");
        if (log_en && i_gnt) glog.push_back("I");

        // memory responder
        acc = p_rst && reset && p_mreq && p_mrdy;
        mem_ready = 0; mem_rvalid = 0;
        if (!reset) begin
            resp_cnt = -1; req_age = 0;
        end else begin
            if (acc) begin
                rd_idx = int'(p_maddr[5:2]);
                if (p_mwe)
                    for (int b = 0; b < MW; b++)
                        if (p_mwmask[b]) mem[rd_idx][8*b +: 8] = p_mwdata[8*b +: 8];
                resp_cnt = (rsp_fixed >= 0) ? rsp_fixed : int'($urandom_range(0, 3));
            end
            if (resp_cnt == 0) begin
                mem_rvalid = 1; mem_rdata = mem[rd_idx]; resp_cnt = -1;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
            end else if (spur_en && $urandom_range(0, 5) == 0) begin
                mem_rvalid = 1; mem_rdata = $urandom;
            end
            if (mem_req) begin
                req_age++;
                mem_ready = (ready_hold >= 0) ? (req_age > ready_hold) : ($urandom_range(0, 2) != 0);
            end else req_age = 0;
        end

        // requester agents
        if (i_mode == 2) i_req = 1;
        else begin
            if (i_gnt) i_req = 0;
            if (i_mode == 1 && !i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_addr = {26'h0, 4'($urandom), 2'b00};
            end
        end
        if (d_mode == 2) d_req = 1;
        else begin
            if (d_gnt) d_req = 0;
            if (d_mode == 1 && !d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = 1'($urandom); d_addr = 32'($urandom_range(0, 63));
                d_wdata = $urandom; d_wmask = 4'($urandom);
            end
        end
    endtask

    task automatic rst_pulse(input int n);
        i_mode = 0; d_mode = 0; i_req = 0; d_req = 0; reset = 0;
        repeat (n) cycle();
        reset = 1;
    endtask

    initial begin
        string order;
        for (int k = 0; k < 16; k++) mem[k] = $urandom;

        // reset held with a pending fetch, then release
        i_req = 1; i_addr = 32'h24;
        repeat (3) cycle();
        chk("t1_rst_outs", {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, mem_req, mem_we, mem_addr}, '0);
        chk("t1_rst_wide", {d_rdata, mem_wdata}, '0);
        reset = 1;
        cycle();
        chk("t1_i_gnt", i_gnt, 1);
        chk("t1_addr", mem_addr, 32'h24);
        chk("t1_we", mem_we, 0);
        repeat (8) cycle();

        // simultaneous requests: store wins, then fetch
        rst_pulse(2); ready_hold = 0; rsp_fixed = 0;
        i_req = 1; i_addr = 32'h8; d_req = 1; d_we = 1; d_addr = 32'h100;
        d_wdata = 32'hDEADBEEF; d_wmask = 4'hF; cnt_drv = 0;
        cycle();
        chk("t2_d_gnt", {d_gnt, i_gnt}, 2'b10);
        chk("t2_payload", {mem_we, mem_addr, mem_wdata, mem_wmask}, {1'b1, 32'h100, 32'hDEADBEEF, 4'hF});
        for (int k = 0; k < 20 && !i_gnt; k++) cycle();
        chk("t2_i_gnt", i_gnt, 1);
        chk("t2_d_rvalid_first", cnt_drv, 1);
        repeat (6) cycle();

        // both held high: streak limit lets fetch in every fifth grant
        rst_pulse(2); glog.delete(); log_en = 1; i_mode = 2; d_mode = 2;
        d_we = 0; d_addr = 32'h4;
        repeat (40) cycle();
        log_en = 0; i_mode = 0; d_mode = 0;
        order = "DDDDIDDDDI";
        chk("t3_count", glog.size() >= 10, 1);
        for (int k = 0; k < 10 && k < glog.size(); k++) chk("t3_order", glog[k], order[k]);
        repeat (10) cycle();

        // slow memory accept and response
        rst_pulse(2); ready_hold = 3; rsp_fixed = 2; mem[0] = 32'h00000013;
        i_req = 1; i_addr = 32'h40; cnt_mreq = 0; cnt_irv = 0;
        repeat (14) cycle();
        chk("t4_mreq_cycles", cnt_mreq, 4);
        chk("t4_irv_pulses", cnt_irv, 1);
        chk("t4_i_rdata", i_rdata, 32'h13);

        // reset in the middle of a load's wait phase
        rst_pulse(2); ready_hold = 0; rsp_fixed = 6;
        d_req = 1; d_we = 0; d_addr = 32'h8;
        for (int k = 0; k < 10 && phase != 2; k++) cycle();
        chk("t6_reached_wait", phase == 2, 1);
        reset = 0; cnt_drv = 0; cnt_irv = 0;
        repeat (2) cycle();
        reset = 1;
        repeat (8) cycle();
        chk("t6_no_rvalid", cnt_drv + cnt_irv, 0);
        chk("t6_mem_req", mem_req, 0);
        rsp_fixed = 0; d_req = 1; d_addr = 32'hC;
        for (int k = 0; k < 5 && !d_gnt; k++) cycle();
        chk("t6_regrant", d_gnt, 1);
        repeat (6) cycle();

        // randomized traffic with stray memory responses and a mid-run reset
        ready_hold = -1; rsp_fixed = -1; spur_en = 1; i_mode = 1; d_mode = 1;
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) begin
                reset = 0; cycle(); cycle(); reset = 1;
            end
            cycle();
        end
        i_mode = 0; d_mode = 0; spur_en = 0;
        repeat (30) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
